mem_dump_engine: RTL and testbench

Post-run data-memory readout block for the pipelined CPU. Watches the fetch PC for a halt loop (branch-to-self) or accepts an explicit start request. Once triggered, it reads the data RAM word by word through the RAM's read port and streams address/data pairs out over a valid/ready handshake. It sits beside the pipeline, sharing the RAM read port after the core has stopped writing, and is the hardware counterpart of the program/RAM loader path.

---
 rtl/mem_dump_engine.sv | 150 +++++++++++++++
 tb/tb_mem_dump_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_engine.sv
// Reads the data RAM word by word after a halt loop or a start pulse and streams addr/data out; MEM_DUMP_SKIP_ZERO_EN drops zero words.
// Latency: trigger edge N -> READ in cycle N+1 -> dump_valid in cycle N+2; 2 cycles per word with dump_ready high.
// Backpressure: SEND holds addr/data/last stable for as long as dump_ready stays low.
module mem_dump_engine #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int HALT_REPEAT = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [31:0]       PC,
    input  logic              PC_LE,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_Address,
    output logic              mem_Enable,
    output logic              mem_ReadWrite,
    output logic              mem_Size,
    input  logic [31:0]       mem_DataOut,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [31:0]       dump_data,
    output logic              dump_last,
    output logic              halt_detected,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    localparam int                CNT_W     = $clog2(HALT_REPEAT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(HALT_REPEAT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 4);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       h0_q, h0_d, h1_q, h1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
    logic [31:0]       dump_data_q, dump_data_d;
    logic              dump_last_q, dump_last_d;
    logic              halt_q, halt_d;
    logic              halt_hit;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        h0_d        = h0_q;
        h1_d        = h1_q;
        cnt_d       = cnt_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;
        dump_last_d = dump_last_q;
        halt_d      = halt_q;
        halt_hit    = 1'b0;
        mem_Address = '0;
        mem_Enable  = 1'b0;
        mem_Size    = 1'b0;
        dump_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                if (PC_LE) begin
                    // Two-entry history so an L / L+4 alternation still counts as a repeat.
                    h1_d = h0_q;
                    h0_d = PC;
                    if (PC == h0_q || PC == h1_q)
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    else
                        cnt_d = '0;
                    halt_hit = (cnt_d == CNT_MAX);
                end
                if (halt_hit)
                    halt_d = 1'b1;
                if (start || halt_hit) begin
                    state_d = READ;
                    addr_d  = '0;
                end
            end
            READ: begin
                mem_Address = addr_q;
                mem_Enable  = 1'b1;
                mem_Size    = 1'b1;
`ifdef MEM_DUMP_SKIP_ZERO_EN
                if (mem_DataOut == 32'h0 && addr_q != LAST_ADDR) begin
                    addr_d = addr_q + WORD_STEP;
                end else begin
                    dump_data_d = mem_DataOut;
                    dump_addr_d = addr_q;
                    dump_last_d = (addr_q == LAST_ADDR);
                    state_d     = SEND;
                end
`else
                dump_data_d = mem_DataOut;
                dump_addr_d = addr_q;
                dump_last_d = (addr_q == LAST_ADDR);
                state_d     = SEND;
`endif
            end
            SEND: begin
                dump_valid = 1'b1;
                if (dump_ready) begin
                    if (dump_last_q) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + WORD_STEP;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            h0_q        <= '0;
            h1_q        <= '0;
            cnt_q       <= '0;
            dump_addr_q <= '0;
            dump_data_q <= '0;
            dump_last_q <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            h0_q        <= h0_d;
            h1_q        <= h1_d;
            cnt_q       <= cnt_d;
            dump_addr_q <= dump_addr_d;
            dump_data_q <= dump_data_d;
            dump_last_q <= dump_last_d;
            halt_q      <= halt_d;
        end
    end

    assign mem_ReadWrite = 1'b0;
    assign dump_addr     = dump_addr_q;
    assign dump_data     = dump_data_q;
    assign dump_last     = dump_last_q;
    assign halt_detected = halt_q;
    assign busy          = (state_q == READ) || (state_q == SEND);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_mem_dump_engine.sv
// Directed bench for mem_dump_engine: manual dump, back-pressure, reset mid-dump, halt detection, corner triggers.
module tb_mem_dump_engine;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PC;
    logic        PC_LE;
    logic        start;
    logic [7:0]  mem_Address;
    logic        mem_Enable;
    logic        mem_ReadWrite;
    logic        mem_Size;
    logic [31:0] mem_DataOut;
    logic        dump_valid;
    logic        dump_ready;
    logic [7:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_last;
    logic        halt_detected;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

`ifdef MEM_DUMP_SKIP_ZERO_EN
    localparam int NWORDS = 3;
    localparam int NCYC   = 67;
`else
    localparam int NWORDS = 64;
    localparam int NCYC   = 128;
`endif

    logic [31:0] ram [0:63];
    assign mem_DataOut = ram[mem_Address[7:2]];

    mem_dump_engine #(.ADDR_W(8), .DEPTH(256), .HALT_REPEAT(12)) dut (
        .Clk(Clk), .Reset(Reset), .PC(PC), .PC_LE(PC_LE), .start(start),
        .mem_Address(mem_Address), .mem_Enable(mem_Enable), .mem_ReadWrite(mem_ReadWrite),
        .mem_Size(mem_Size), .mem_DataOut(mem_DataOut),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_last(dump_last),
        .halt_detected(halt_detected), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] exp_word(input int a);
        logic [7:0] b;
        if (a == 0) return 32'hE3A01005;
        if (a == 4) return 32'h00000007;
`ifdef MEM_DUMP_SKIP_ZERO_EN
        b = 8'h00;
`else
        b = 8'(a / 4);
`endif
        return {b, b, b, b};
    endfunction

    function automatic int next_addr(input int a);
`ifdef MEM_DUMP_SKIP_ZERO_EN
        return (a < 4) ? a + 4 : 252;
`else
        return a + 4;
`endif
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    // Called in the cycle after the trigger edge; runs until done or the bound expires.
    task automatic run_dump(input bit do_chk, output int n, output int cyc, output int first_cyc);
        int ea;
        ea = 0;
        n = 0;
        cyc = 0;
        first_cyc = -1;
        while (!done && cyc < 400) begin
            if (dump_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (do_chk) begin
                    check("word_addr", dump_addr, ea);
                    check("word_data", dump_data, exp_word(ea));
                    check("word_last", dump_last, (ea == 252));
                end
                ea = next_addr(ea);
                n++;
            end
            step();
            cyc++;
        end
    endtask

    task automatic halt_seq(input bit with_start);
        do_reset();
        PC_LE = 1'b1;
        for (int i = 0; i < 13; i++) begin
            PC = (i % 2 == 0) ? 32'd40 : 32'd44;
            step();
        end
        check("halt_early_flag", halt_detected, 1'b0);
        check("halt_early_busy", busy, 1'b0);
        PC = 32'd44;
        start = with_start;
        step();
        start = 1'b0;
        check("halt_flag", halt_detected, 1'b1);
        check("halt_busy", busy, 1'b1);
        check("halt_first_addr", mem_Address, 8'd0);
    endtask

    initial begin
        int n, cyc, first_cyc, k;
        for (int i = 0; i < 64; i++) ram[i] = exp_word(i * 4);
        Reset = 1'b1;
        PC = 32'd0;
        PC_LE = 1'b0;
        start = 1'b0;
        dump_ready = 1'b1;

        // Reset state
        do_reset();
        check("rst_valid", dump_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_halt", halt_detected, 1'b0);
        check("rst_enable", mem_Enable, 1'b0);
        check("rst_size", mem_Size, 1'b0);
        check("rst_rw", mem_ReadWrite, 1'b0);
        check("rst_maddr", mem_Address, 8'd0);
        check("rst_daddr", dump_addr, 8'd0);
        check("rst_ddata", dump_data, 32'd0);
        check("rst_last", dump_last, 1'b0);

        // Manual dump
        start = 1'b1;
        step();
        start = 1'b0;
        check("read_busy", busy, 1'b1);
        check("read_enable", mem_Enable, 1'b1);
        check("read_size", mem_Size, 1'b1);
        check("read_rw", mem_ReadWrite, 1'b0);
        check("read_maddr", mem_Address, 8'd0);
        check("read_valid", dump_valid, 1'b0);
        run_dump(1'b1, n, cyc, first_cyc);
        check("manual_first_cycle", first_cyc, 1);
        check("manual_words", n, NWORDS);
        check("manual_cycles", cyc, NCYC);
        check("manual_done", done, 1'b1);
        check("manual_busy", busy, 1'b0);
        check("manual_halt", halt_detected, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("done_start_busy", busy, 1'b0);
        check("done_start_valid", dump_valid, 1'b0);
        check("done_start_done", done, 1'b1);

        // Back-pressure on word 8, then reset at addr 64
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
`ifndef MEM_DUMP_SKIP_ZERO_EN
        k = 0;
        while (!(dump_valid && dump_addr == 8'd8) && k < 50) begin
            step();
            k++;
        end
        check("bp_reach_8", dump_addr, 8'd8);
        dump_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", dump_valid, 1'b1);
            check("bp_addr", dump_addr, 8'd8);
            check("bp_data", dump_data, 32'h02020202);
        end
        dump_ready = 1'b1;
        step();
        check("bp_next_maddr", mem_Address, 8'd12);
        check("bp_next_valid", dump_valid, 1'b0);
        step();
        check("bp_next_daddr", dump_addr, 8'd12);
        check("bp_next_data", dump_data, 32'h03030303);
`endif
        k = 0;
        while (!(busy && !dump_valid && mem_Address == 8'd64) && k < 200) begin
            step();
            k++;
        end
        check("mid_reach_64", mem_Address, 8'd64);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", dump_valid, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_enable", mem_Enable, 1'b0);
        check("mid_rst_maddr", mem_Address, 8'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_maddr", mem_Address, 8'd0);
        check("restart_busy", busy, 1'b1);
        dump_ready = 1'b0;
        step();
        check("restart_daddr", dump_addr, 8'd0);
        check("restart_data", dump_data, 32'hE3A01005);
        start = 1'b1;
        step();
        start = 1'b0;
        check("send_start_valid", dump_valid, 1'b1);
        check("send_start_addr", dump_addr, 8'd0);
        step();
        check("send_start_hold", dump_valid, 1'b1);
        dump_ready = 1'b1;

        // Linear PC never triggers
        do_reset();
        PC_LE = 1'b1;
        for (int i = 0; i < 40; i++) begin
            PC = i * 4;
            step();
        end
        check("linear_halt", halt_detected, 1'b0);
        check("linear_busy", busy, 1'b0);

        // Halt alone, then halt and start together giving one dump
        halt_seq(1'b0);
        halt_seq(1'b1);
        run_dump(1'b0, n, cyc, first_cyc);
        check("both_words", n, NWORDS);
        check("both_done", done, 1'b1);
        for (int i = 0; i < 4; i++) step();
        check("both_done_hold", done, 1'b1);
        check("both_done_busy", busy, 1'b0);
        check("both_halt_sticky", halt_detected, 1'b1);
        PC_LE = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
